// File: rtl/or_4bit.sv
// Four-input OR flag combiner: a zero-latency OR, its registered copy, a one-cycle
// rising-edge pulse on that copy, and per-input sticky "seen-high" status flags.
module or_4bit #(
    parameter bit STICKY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       clr,
    output logic       s,
    output logic       s_q,
    output logic       s_rise,
    output logic [3:0] sticky
);

    logic [3:0] in_vec;
    logic       s_q_reg;
    logic       s_q_d_reg;
    logic       s_rise_reg;

    assign in_vec = {d, c, b, a};
    assign s      = a | b | c | d;

    // s_rise compares the previous two samples of s_q, so it lags s_q by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q_reg    <= 1'b0;
            s_q_d_reg  <= 1'b0;
            s_rise_reg <= 1'b0;
        end else begin
            s_q_reg    <= s;
            s_q_d_reg  <= s_q_reg;
            s_rise_reg <= s_q_reg & ~s_q_d_reg;
        end
    end

    assign s_q    = s_q_reg;
    assign s_rise = s_rise_reg;

    generate
        if (STICKY_EN) begin : g_sticky
            logic [3:0] sticky_reg;
            for (genvar gi = 0; gi < 4; gi++) begin : g_bit
                // Clear takes priority over a simultaneous high input.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        sticky_reg[gi] <= 1'b0;
                    end else if (clr) begin
                        sticky_reg[gi] <= 1'b0;
                    end else begin
                        sticky_reg[gi] <= sticky_reg[gi] | in_vec[gi];
                    end
                end
            end
            assign sticky = sticky_reg;
        end else begin : g_no_sticky
            assign sticky = 4'b0000;
        end
    endgenerate

endmodule

// File: tb/tb_or_4bit.sv
// Self-checking bench for or_4bit: truth table under reset, then a cycle-level
// scoreboard run on STICKY_EN=1 and STICKY_EN=0 instances sharing the same stimulus.
module tb_or_4bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic       clr = 1'b0;
    logic       s, s_q, s_rise;
    logic [3:0] sticky;
    logic       s2, s_q2, s_rise2;
    logic [3:0] sticky2;

    int checks   = 0;
    int failures = 0;
    int rise_cnt = 0;

    typedef struct {
        logic [3:0] in;
        logic       exp_s;
    } vec_t;

    typedef struct {
        logic       sq;
        logic       rise;
        logic [3:0] st;
    } exp_t;

    vec_t tv[16];
    exp_t sb[$];

    logic       m_sq  = 1'b0;
    logic       m_sqd = 1'b0;
    logic [3:0] m_st  = 4'b0000;

    or_4bit #(.STICKY_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .clr(clr),
        .s(s), .s_q(s_q), .s_rise(s_rise), .sticky(sticky)
    );

    or_4bit #(.STICKY_EN(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .clr(clr),
        .s(s2), .s_q(s_q2), .s_rise(s_rise2), .sticky(sticky2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {d, c, b, a} = v;
    endtask

    task automatic model_reset();
        m_sq  = 1'b0;
        m_sqd = 1'b0;
        m_st  = 4'b0000;
    endtask

    // Called at a negedge: drive, predict the post-edge state, wait, then compare.
    task automatic cycle(input logic [3:0] v, input logic cl);
        exp_t e;
        exp_t got;
        logic s_exp;
        drive(v);
        clr = cl;
        #1;
        s_exp = (v != 4'b0000);
        chk("s_comb", s, s_exp);
        chk("s_comb_ns", s2, s_exp);
        e.rise = m_sq & ~m_sqd;
        e.sq   = s_exp;
        e.st   = cl ? 4'b0000 : (m_st | v);
        m_sqd  = m_sq;
        m_sq   = s_exp;
        m_st   = e.st;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = sb.pop_front();
        chk("s_q", s_q, got.sq);
        chk("s_rise", s_rise, got.rise);
        chk("sticky", sticky, got.st);
        chk("s_q_ns", s_q2, got.sq);
        chk("s_rise_ns", s_rise2, got.rise);
        chk("sticky_ns", sticky2, 4'b0000);
        if (s_rise === 1'b1) rise_cnt++;
        $display("cycle in=%b clr=%b s=%b s_q=%b s_rise=%b sticky=%b", v, cl, s, s_q, s_rise, sticky);
    endtask

    initial begin
        logic [3:0] walk_exp [4];
        walk_exp[0] = 4'b0001;
        walk_exp[1] = 4'b0011;
        walk_exp[2] = 4'b0111;
        walk_exp[3] = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            tv[i].in    = 4'(i);
            tv[i].exp_s = (i == 0) ? 1'b0 : 1'b1;
        end

        // Truth table with reset held: registers must stay cleared.
        for (int i = 0; i < 16; i++) begin
            drive(tv[i].in);
            #2;
            chk("tt_s", s, tv[i].exp_s);
            chk("tt_s_ns", s2, tv[i].exp_s);
            chk("tt_s_q", s_q, 1'b0);
            chk("tt_s_rise", s_rise, 1'b0);
            chk("tt_sticky", sticky, 4'b0000);
            $display("tt in=%b s=%b s_q=%b sticky=%b", tv[i].in, s, s_q, sticky);
        end

        drive(4'b0000);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Registered latency.
        cycle(4'b0000, 1'b0);
        cycle(4'b0001, 1'b0);
        chk("lat_s_q", s_q, 1'b1);
        chk("lat_rise0", s_rise, 1'b0);
        cycle(4'b0001, 1'b0);
        chk("lat_rise1", s_rise, 1'b1);
        cycle(4'b0001, 1'b0);
        chk("lat_rise2", s_rise, 1'b0);

        // Walking one: sticky accumulates, no extra pulses.
        rise_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 4; n++) cycle(4'(1 << k), 1'b0);
            chk("walk_sticky", sticky, walk_exp[k]);
        end
        chk("walk_rises", 4'(rise_cnt), 4'd0);

        // Clear beats a simultaneous high input.
        cycle(4'b1000, 1'b1);
        chk("clr_sticky", sticky, 4'b0000);
        cycle(4'b1000, 1'b0);
        chk("clr_reset", sticky, 4'b1000);

        // Toggling s every cycle pulses on every rising transition of s_q.
        rise_cnt = 0;
        for (int n = 0; n < 7; n++) cycle((n % 2 == 0) ? 4'b0000 : 4'b0010, 1'b0);
        chk("toggle_rises", 4'(rise_cnt), 4'd3);

        // Async reset mid-pulse.
        cycle(4'b0000, 1'b1);
        cycle(4'b0101, 1'b0);
        chk("pre_rst_sticky", sticky, 4'b0101);
        cycle(4'b0101, 1'b0);
        chk("pre_rst_rise", s_rise, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_s_q", s_q, 1'b0);
        chk("arst_s_rise", s_rise, 1'b0);
        chk("arst_sticky", sticky, 4'b0000);
        chk("arst_s", s, 1'b1);
        chk("arst_s_q_ns", s_q2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("hold_s_q", s_q, 1'b0);
        chk("hold_sticky", sticky, 4'b0000);
        $display("reset s=%b s_q=%b s_rise=%b sticky=%b", s, s_q, s_rise, sticky);
        rst = 1'b0;

        // Release with s=1: legitimate rise from the reset value.
        cycle(4'b0101, 1'b0);
        chk("rel_s_q", s_q, 1'b1);
        chk("rel_rise0", s_rise, 1'b0);
        cycle(4'b0101, 1'b0);
        chk("rel_rise1", s_rise, 1'b1);
        cycle(4'b0101, 1'b0);
        chk("rel_rise2", s_rise, 1'b0);

        drive(4'b0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/or_4bit.md
Name: or_4bit

Overview:
- Four-input, single-bit OR gate with a registered companion path, used as a small glue/flag-combining block.
- Primary function is the combinational output s = a | b | c | d, with zero latency.
- Also provides:
  - a clocked copy of s,
  - a rising-edge pulse on that copy,
  - per-input sticky "seen-high" flags for debug/status.

Parameters:
- STICKY_EN, 1, when 1 the sticky flag register is implemented; when 0 the sticky outputs are tied to 4'b0000.

Ports:
- clk     input   1  system clock; all registers update on its rising edge.
- rst     input   1  asynchronous, active-high reset.
- a       input   1  OR operand 0.
- b       input   1  OR operand 1.
- c       input   1  OR operand 2.
- d       input   1  OR operand 3.
- clr     input   1  synchronous clear of the sticky flags (active-high).
- s       output  1  combinational OR of a, b, c, d.
- s_q     output  1  s registered by one clk cycle.
- s_rise  output  1  one-cycle pulse when s_q transitions 0 -> 1.
- sticky  output  4  {d,c,b,a} seen-high flags; bit0 = a, bit3 = d.

Behaviour:
- Combinational path:
  - s = a | b | c | d at all times, independent of clk and rst.
  - s is 1 if any input is 1, and 0 only when all four inputs are 0.
  - No latency; s follows input changes within the same delta/timestep.
- Registered path:
  - s_q <= s on each rising clk edge. Latency is 1 cycle.
- Edge pulse:
  - A register s_q_d holds the previous s_q.
  - s_rise = s_q & ~s_q_d, registered so that it is high for exactly one cycle: the cycle after s_q first becomes 1.
  - Continuous s = 1 produces a single pulse only.
  - A 0 -> 1 -> 0 -> 1 toggle on s at every cycle produces a pulse on every rising transition.
- Sticky flags:
  - On each rising clk edge: sticky[i] <= clr ? 1'b0 : (sticky[i] | in[i]), where in = {d,c,b,a}.
  - If clr and an input are high in the same cycle, clr wins: the bit is 0 after that edge. It sets again on the next edge if the input stays high.
- Reset:
  - rst = 1 immediately (asynchronously) forces s_q = 0, s_q_d = 0, s_rise = 0 and sticky = 4'b0000.
  - Registers hold these values while rst is high.
  - s is unaffected by rst.
  - On rst deassertion, the first clk edge loads s_q from the current s.
  - If s = 1 at that point, s_rise pulses on the following cycle. This is a legitimate 0 -> 1 transition from the reset value.
  - Reset asserted mid-pulse clears s_rise at once.
- Unknown inputs:
  - X/Z on any input propagates per standard OR semantics: a 1 on any input dominates; otherwise the result is X.
  - Benches shall drive all inputs to defined values before checking.
- Widths: all data is 1-bit; no arithmetic.

Test Plan:
- Exhaustive truth table: sweep {d,c,b,a} through all 16 values with rst held -> s = 0 only for 4'b0000 and s = 1 for the other 15; s_q = 0 and sticky = 0 throughout.
- Registered latency: release rst; set a = 1 (others 0) just after a clk edge -> s = 1 immediately; s_q = 1 after the next edge; s_rise = 1 for exactly one cycle after that, then 0 while a stays 1.
- Walking one: drive a, then b, then c, then d high one at a time, each for 4 cycles with the others 0 -> s = 1 throughout; sticky progresses 0001, 0011, 0111, 1111; s_rise does not re-pulse.
- Clear priority: with sticky = 1111 and d = 1, assert clr for one cycle -> sticky = 0000 after that edge and 1000 after the next edge.
- Async reset mid-operation: with s_q = 1 and sticky = 0101, assert rst between clk edges -> s_q, s_rise and sticky go to 0 immediately; s still equals the OR of the live inputs.
- STICKY_EN = 0: repeat the walking-one scenario -> sticky stays 0000; s, s_q and s_rise behave identically to STICKY_EN = 1.
